// File: rtl/ram_dualport_be_pkg.sv
// ram_dualport_be_pkg: read-during-write mode codes and byte-lane derivation
package ram_dualport_be_pkg;
  localparam int RDW_WRITE_FIRST = 0;
  localparam int RDW_READ_FIRST = 1;
  localparam int RDW_NO_CHANGE = 2;
  function automatic int lanes(input int dw, input int bw);
    return dw / bw;
  endfunction
endpackage

// File: rtl/ram_dualport_be_if.sv
// ram_dualport_be_if: access requests and read responses of both RAM ports
interface ram_dualport_be_if
  import ram_dualport_be_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 8,
  parameter int RAM_DATA_WIDTH = 8,
  parameter int RAM_BYTE_WIDTH = 8
);
  localparam int NB = lanes(RAM_DATA_WIDTH, RAM_BYTE_WIDTH);
  logic in_en_a, in_en_b, in_wr_a, in_wr_b;
  logic [NB-1:0] in_be_a, in_be_b;
  logic [RAM_ADDR_WIDTH-1:0] in_addr_a, in_addr_b;
  logic [RAM_DATA_WIDTH-1:0] in_data_a, in_data_b;
  logic [RAM_DATA_WIDTH-1:0] out_data_a, out_data_b;
  logic out_valid_a, out_valid_b, out_collision;
  modport master (
    output in_en_a, in_en_b, in_wr_a, in_wr_b, in_be_a, in_be_b,
    output in_addr_a, in_addr_b, in_data_a, in_data_b,
    input out_data_a, out_data_b, out_valid_a, out_valid_b, out_collision
  );
  modport slave (
    input in_en_a, in_en_b, in_wr_a, in_wr_b, in_be_a, in_be_b,
    input in_addr_a, in_addr_b, in_data_a, in_data_b,
    output out_data_a, out_data_b, out_valid_a, out_valid_b, out_collision
  );
endinterface

// File: rtl/ram_dualport_be_port_out.sv
// ram_dualport_be_port_out: per-port read word select, optional output register and valid pipeline
module ram_dualport_be_port_out
  import ram_dualport_be_pkg::*;
#(
  parameter int DW = 8,
  parameter int OUT_REG = 0,
  parameter int RDW_MODE = 0
) (
  input  logic          in_clk,
  input  logic          in_rst,
  input  logic          acc,
  input  logic          wr,
  input  logic [DW-1:0] old_word,
  input  logic [DW-1:0] merged_word,
  output logic [DW-1:0] data,
  output logic          valid
);
  logic upd;
  logic [DW-1:0] rd_word, data1_d, data1_q, data2_d, data2_q;
  logic valid1_d, valid1_q, valid2_d, valid2_q;
  // pick the returned word; a no-change write yields no result and leaves the data held
  always_comb begin
    upd = acc && !(wr && RDW_MODE == RDW_NO_CHANGE);
    rd_word = (wr && RDW_MODE == RDW_WRITE_FIRST) ? merged_word : old_word;
    data1_d = in_rst ? '0 : upd ? rd_word : data1_q;
    valid1_d = !in_rst && upd;
    data2_d = in_rst ? '0 : valid1_q ? data1_q : data2_q;
    valid2_d = !in_rst && valid1_q;
  end
  // both stages always exist; the second is only exposed when the output register is selected
  always_ff @(posedge in_clk) begin
    data1_q <= data1_d;
    valid1_q <= valid1_d;
    data2_q <= data2_d;
    valid2_q <= valid2_d;
  end
  assign data = OUT_REG != 0 ? data2_q : data1_q;
  assign valid = OUT_REG != 0 ? valid2_q : valid1_q;
endmodule

// File: rtl/ram_dualport_be.sv
// ram_dualport_be: true dual-port RAM with byte-lane writes, RDW modes and collision flag
module ram_dualport_be
  import ram_dualport_be_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 8,
  parameter int RAM_DATA_WIDTH = 8,
  parameter int RAM_BYTE_WIDTH = 8,
  parameter int RAM_OUT_REG = 0,
  parameter int RAM_RDW_MODE = 0
) (
  input logic in_clk,
  input logic in_rst,
  ram_dualport_be_if.slave bus
);
  localparam int NB = lanes(RAM_DATA_WIDTH, RAM_BYTE_WIDTH);
  localparam int DEPTH = 2 ** RAM_ADDR_WIDTH;
  logic [NB-1:0][RAM_BYTE_WIDTH-1:0] mem_q [DEPTH];
  logic [NB-1:0][RAM_BYTE_WIDTH-1:0] old_a, old_b, new_a, new_b, mrg_a, mrg_b;
  logic [NB-1:0] we_a, we_b;
  logic acc_a, acc_b, wr_a, wr_b, same, collision_d, collision_q;
  // qualify accesses, fetch pre-write words, build merged words; A owns shared lanes on a shared address
  always_comb begin
    acc_a = bus.in_en_a && !in_rst;
    acc_b = bus.in_en_b && !in_rst;
    wr_a = acc_a && bus.in_wr_a;
    wr_b = acc_b && bus.in_wr_b;
    same = bus.in_addr_a == bus.in_addr_b;
    we_a = wr_a ? bus.in_be_a : '0;
    we_b = (wr_b ? bus.in_be_b : '0) & ~(same ? we_a : '0);
    old_a = mem_q[bus.in_addr_a];
    old_b = mem_q[bus.in_addr_b];
    new_a = bus.in_data_a;
    new_b = bus.in_data_b;
    for (int i = 0; i < NB; i++) begin
      mrg_a[i] = bus.in_be_a[i] ? new_a[i] : old_a[i];
      mrg_b[i] = bus.in_be_b[i] ? new_b[i] : old_b[i];
    end
    collision_d = acc_a && acc_b && same && (bus.in_wr_a || bus.in_wr_b);
  end
  // lane writes and the registered collision flag (accesses are already gated off in reset)
  always_ff @(posedge in_clk) begin
    for (int i = 0; i < NB; i++) begin
      if (we_a[i]) mem_q[bus.in_addr_a][i] <= new_a[i];
      if (we_b[i]) mem_q[bus.in_addr_b][i] <= new_b[i];
    end
    collision_q <= in_rst ? 1'b0 : collision_d;
  end
  assign bus.out_collision = collision_q;
  ram_dualport_be_port_out #(.DW(RAM_DATA_WIDTH), .OUT_REG(RAM_OUT_REG), .RDW_MODE(RAM_RDW_MODE)) u_out_a (
    .in_clk(in_clk), .in_rst(in_rst), .acc(acc_a), .wr(wr_a), .old_word(old_a),
    .merged_word(mrg_a), .data(bus.out_data_a), .valid(bus.out_valid_a)
  );
  ram_dualport_be_port_out #(.DW(RAM_DATA_WIDTH), .OUT_REG(RAM_OUT_REG), .RDW_MODE(RAM_RDW_MODE)) u_out_b (
    .in_clk(in_clk), .in_rst(in_rst), .acc(acc_b), .wr(wr_b), .old_word(old_b),
    .merged_word(mrg_b), .data(bus.out_data_b), .valid(bus.out_valid_b)
  );
endmodule

// File: tb/tb_ram_dualport_be.sv
// tb_ram_dualport_be: six RAM configurations driven in lockstep against a word-level reference model
module tb_ram_dualport_be;
  import ram_dualport_be_pkg::*;
  localparam int AW = 8, DW = 32, BW = 8, NB = 4, NI = 6, NT = 4096;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, en_a, en_b, wr_a, wr_b;
  logic [NB-1:0] be_a, be_b;
  logic [AW-1:0] ad_a, ad_b;
  logic [DW-1:0] di_a, di_b;
  logic [DW-1:0] od_a [NI];
  logic [DW-1:0] od_b [NI];
  logic ov_a [NI];
  logic ov_b [NI];
  logic oc [NI];
  genvar g;
  for (g = 0; g < NI; g++) begin : gi
    ram_dualport_be_if #(.RAM_ADDR_WIDTH(AW), .RAM_DATA_WIDTH(DW), .RAM_BYTE_WIDTH(BW)) bus ();
    assign bus.in_en_a = en_a;
    assign bus.in_en_b = en_b;
    assign bus.in_wr_a = wr_a;
    assign bus.in_wr_b = wr_b;
    assign bus.in_be_a = be_a;
    assign bus.in_be_b = be_b;
    assign bus.in_addr_a = ad_a;
    assign bus.in_addr_b = ad_b;
    assign bus.in_data_a = di_a;
    assign bus.in_data_b = di_b;
    assign od_a[g] = bus.out_data_a;
    assign od_b[g] = bus.out_data_b;
    assign ov_a[g] = bus.out_valid_a;
    assign ov_b[g] = bus.out_valid_b;
    assign oc[g] = bus.out_collision;
    ram_dualport_be #(
      .RAM_ADDR_WIDTH(AW), .RAM_DATA_WIDTH(DW), .RAM_BYTE_WIDTH(BW),
      .RAM_OUT_REG(g % 2), .RAM_RDW_MODE(g / 2)
    ) dut (.in_clk(clk), .in_rst(rst), .bus(bus));
  end
  logic [DW-1:0] mm [2**AW];
  bit ev [NI][2][NT];
  logic [DW-1:0] ed [NI][2][NT];
  bit ec [NT];
  bit rst_at [NT];
  logic [DW-1:0] hold [NI][2];
  int c = 1;
  int n_chk = 0;
  int n_fail = 0;
  bit dchk = 1'b1;
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n, input logic [NB-1:0] be);
    logic [DW-1:0] r;
    r = o;
    for (int i = 0; i < NB; i++) if (be[i]) r[i*BW +: BW] = n[i*BW +: BW];
    return r;
  endfunction
  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (rst_at[c]) hold[k][p] = '0;
        else if (ev[k][p][c]) hold[k][p] = ed[k][p][c];
        if (dchk) chk($sformatf("i%0d.%s.data@%0d", k, p ? "b" : "a", c), p ? od_b[k] : od_a[k], hold[k][p]);
        chk($sformatf("i%0d.%s.valid@%0d", k, p ? "b" : "a", c), p ? ov_b[k] : ov_a[k], DW'(ev[k][p][c]));
      end
      chk($sformatf("i%0d.collision@%0d", k, c), oc[k], DW'(ec[c]));
    end
  endtask
  task automatic drive(input bit r, input bit ea, input bit wa, input logic [NB-1:0] ba, input logic [AW-1:0] aa,
                       input logic [DW-1:0] da, input bit eb, input bit wb, input logic [NB-1:0] bb,
                       input logic [AW-1:0] ab, input logic [DW-1:0] db);
    logic [DW-1:0] oa, ob;
    bit xa, xb;
    int lat, mode;
    rst = r; en_a = ea; wr_a = wa; be_a = ba; ad_a = aa; di_a = da;
    en_b = eb; wr_b = wb; be_b = bb; ad_b = ab; di_b = db;
    oa = mm[aa];
    ob = mm[ab];
    xa = ea && !r;
    xb = eb && !r;
    for (int k = 0; k < NI; k++) begin
      lat = k % 2 + 1;
      mode = k / 2;
      if (xa && !(wa && mode == RDW_NO_CHANGE)) begin
        ev[k][0][c+lat] = 1'b1;
        ed[k][0][c+lat] = (wa && mode == RDW_WRITE_FIRST) ? merge(oa, da, ba) : oa;
      end
      if (xb && !(wb && mode == RDW_NO_CHANGE)) begin
        ev[k][1][c+lat] = 1'b1;
        ed[k][1][c+lat] = (wb && mode == RDW_WRITE_FIRST) ? merge(ob, db, bb) : ob;
      end
    end
    if (r) begin
      rst_at[c+1] = 1'b1;
      for (int k = 0; k < NI; k++) for (int p = 0; p < 2; p++) ev[k][p][c+1] = 1'b0;
    end
    ec[c+1] = xa && xb && aa == ab && (wa || wb);
    if (xb && wb) mm[ab] = merge(mm[ab], db, bb);
    if (xa && wa) mm[aa] = merge(mm[aa], da, ba);
    c++;
  endtask
  task automatic idle();
    drive(0, 0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
  endtask
  initial begin
    logic [AW-1:0] ra, rb;
    rst = 1; en_a = 0; en_b = 0; wr_a = 0; wr_b = 0; be_a = '0; be_b = '0;
    ad_a = '0; ad_b = '0; di_a = '0; di_b = '0;
    rst_at[1] = 1'b1;
    tick(); drive(1, 1, 0, '0, '0, '0, 1, 0, '0, '0, '0);
    tick(); drive(1, 0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
    tick();
    dchk = 1'b0;
    for (int i = 0; i < 128; i++) begin
      drive(0, 1, 1, 4'hF, AW'(2 * i), $urandom, 1, 1, 4'hF, AW'(2 * i + 1), $urandom);
      tick();
    end
    drive(1, 0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
    dchk = 1'b1;
    tick(); drive(0, 1, 1, 4'h1, 8'h10, 32'hAA, 0, 0, '0, '0, '0);
    tick(); drive(0, 0, 0, '0, '0, '0, 1, 0, '0, 8'h10, '0);
    tick(); chk("p1_b_data", DW'(od_b[0][7:0]), 32'hAA); chk("p1_b_valid", DW'(ov_b[0]), 1); idle();
    tick(); chk("p1_b_data_reg", DW'(od_b[1][7:0]), 32'hAA); chk("p1_b_valid_reg", DW'(ov_b[1]), 1);
    drive(0, 1, 1, 4'hF, 8'h05, 32'h11223344, 0, 0, '0, '0, '0);
    tick(); drive(0, 1, 1, 4'b0101, 8'h05, 32'hAABBCCDD, 0, 0, '0, '0, '0);
    tick(); chk("p2_write_first", od_a[0], 32'h11BB33DD); chk("p2_read_first", od_a[2], 32'h11223344);
    chk("p2_no_change_valid", DW'(ov_a[4]), 0);
    drive(0, 1, 0, '0, 8'h05, '0, 0, 0, '0, '0, '0);
    tick(); chk("p2_readback", od_a[0], 32'h11BB33DD); chk("p2_readback_nc", od_a[4], 32'h11BB33DD);
    drive(0, 1, 1, 4'hF, 8'h20, 32'h55, 1, 0, '0, 8'h20, '0);
    tick(); chk("p3_collision", DW'(oc[0]), 1); drive(0, 0, 0, '0, '0, '0, 1, 0, '0, 8'h20, '0);
    tick(); chk("p3_new_data", od_b[0], 32'h55);
    drive(0, 1, 1, 4'b0010, 8'h30, 32'hAAAA, 1, 1, 4'b0011, 8'h30, 32'hBBBB);
    tick(); chk("p4_collision", DW'(oc[0]), 1); drive(0, 1, 0, '0, 8'h30, '0, 0, 0, '0, '0, '0);
    tick(); chk("p4_merge", DW'(od_a[0][15:0]), 32'hAABB);
    drive(1, 1, 1, 4'hF, 8'h30, 32'hDEAD0000, 0, 0, '0, '0, '0);
    tick(); chk("p6_rst_data", od_a[0], 0); chk("p6_rst_valid", DW'(ov_a[0]), 0);
    drive(0, 1, 0, '0, 8'h30, '0, 0, 0, '0, '0, '0);
    tick(); chk("p6_kept", DW'(od_a[0][15:0]), 32'hAABB);
    for (int n = 0; n < 2000; n++) begin
      ra = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, NB'($urandom), ra,
            $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, NB'($urandom), rb, $urandom);
      tick();
    end
    idle(); tick();
    idle(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
